// File: rtl/sub_norm_26b_if.sv
// rtl/sub_norm_26b_if.sv - input/output handshake bundle of the sub_norm_26b normalization stage
interface sub_norm_26b_if #(
    parameter int EXP_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [26:0]      sum;
    logic             ovf;
    logic [EXP_W-1:0] exp_in;
    logic             sign_in;
    logic             out_valid;
    logic             out_ready;
    logic [25:0]      frac_out;
    logic             sticky;
    logic [EXP_W-1:0] exp_out;
    logic             sign_out;
    logic             zero;
    logic             denorm;
    logic             inf;

    modport master (
        output in_valid, sum, ovf, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, frac_out, sticky, exp_out, sign_out, zero, denorm, inf
    );

    modport slave (
        input  in_valid, sum, ovf, exp_in, sign_in, out_ready,
        output in_ready, out_valid, frac_out, sticky, exp_out, sign_out, zero, denorm, inf
    );
endinterface

// File: rtl/sub_norm_26b.sv
// rtl/sub_norm_26b.sv - post-subtract normalizer, hidden bit to [25]; SUB_NORM_LZC_EN selects single-cycle full shift
module sub_norm_26b #(
    parameter int SHIFT_STEP = 4,
    parameter int EXP_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    sub_norm_26b_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

`ifdef SUB_NORM_LZC_EN
    localparam int STEP = 28;
`else
    localparam int STEP = SHIFT_STEP;
`endif
    localparam logic [EXP_W:0] E_ONE  = 1;
    localparam logic [EXP_W:0] E_TWO  = 2;
    localparam logic [EXP_W:0] E_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] STEP_E = STEP;

    state_t           state_q, state_d;
    logic [27:0]      v_q, v_d;
    logic [EXP_W:0]   e_q, e_d;
    logic             sign_q, sign_d;
    logic             sticky_q, sticky_d;
    logic [25:0]      frac_q, frac_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             zero_q, zero_d;
    logic             denorm_q, denorm_d;
    logic             inf_q, inf_d;
    logic             valid_q, valid_d;

    logic [4:0]       lz;
    logic [EXP_W:0]   e_room, s;
    logic             fin, fden;
    logic [27:0]      fv;
    logic [EXP_W:0]   fe;

    // Distance from the leading one to bit 25; only meaningful when v[27:25]==0
    always_comb begin
        lz = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (v_q[i]) lz = 5'(25 - i);
        end
    end

    // The exponent may never be driven below 1 by a left shift
    always_comb begin
        e_room = (e_q > E_ONE) ? (e_q - E_ONE) : '0;
        s      = (EXP_W+1)'(lz);
        if (s > STEP_E) s = STEP_E;
        if (s > e_room) s = e_room;
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        e_d      = e_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        frac_d   = frac_q;
        exp_d    = exp_q;
        zero_d   = zero_q;
        denorm_d = denorm_q;
        inf_d    = inf_q;
        valid_d  = valid_q;
        fin      = 1'b0;
        fden     = 1'b0;
        fv       = v_q;
        fe       = e_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = NORM;
                    v_d      = {bus.ovf, bus.sum};
                    e_d      = {1'b0, bus.exp_in};
                    sign_d   = bus.sign_in;
                    sticky_d = 1'b0;
                    zero_d   = 1'b0;
                    denorm_d = 1'b0;
                    inf_d    = 1'b0;
                end
            end
            NORM: begin
                if (v_q == '0) begin
                    fin = 1'b1;
                end else if (v_q[27]) begin
                    fin      = 1'b1;
                    fv       = v_q >> 2;
                    fe       = e_q + E_TWO;
                    sticky_d = sticky_q | v_q[1] | v_q[0];
                end else if (v_q[26]) begin
                    fin      = 1'b1;
                    fv       = v_q >> 1;
                    fe       = e_q + E_ONE;
                    sticky_d = sticky_q | v_q[0];
                end else if (v_q[25]) begin
                    fin = 1'b1;
                end else begin
                    fv  = v_q << s;
                    fe  = e_q - s;
                    v_d = fv;
                    e_d = fe;
                    if (fv[25]) begin
                        fin = 1'b1;
                    end else if (fe <= E_ONE) begin
                        fin  = 1'b1;
                        fden = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = DONE;
            valid_d = 1'b1;
            if (v_q == '0) begin
                zero_d   = 1'b1;
                exp_d    = '0;
                frac_d   = '0;
                sticky_d = 1'b0;
            end else if (fden) begin
                denorm_d = 1'b1;
                exp_d    = '0;
                frac_d   = fv[25:0];
            end else if (fe >= E_MAX) begin
                inf_d    = 1'b1;
                exp_d    = '1;
                frac_d   = '0;
                sticky_d = 1'b0;
            end else begin
                exp_d  = fe[EXP_W-1:0];
                frac_d = fv[25:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            v_q      <= '0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            frac_q   <= '0;
            exp_q    <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
            inf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            e_q      <= e_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            frac_q   <= frac_d;
            exp_q    <= exp_d;
            zero_q   <= zero_d;
            denorm_q <= denorm_d;
            inf_q    <= inf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.frac_out  = frac_q;
    assign bus.sticky    = sticky_q;
    assign bus.exp_out   = exp_q;
    assign bus.sign_out  = sign_q;
    assign bus.zero      = zero_q;
    assign bus.denorm    = denorm_q;
    assign bus.inf       = inf_q;
endmodule

// File: tb/tb_sub_norm_26b.sv
// tb/tb_sub_norm_26b.sv - self-checking bench for sub_norm_26b against a leading-one-position model
module tb_sub_norm_26b;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_norm_26b_if #(.EXP_W(8)) bus ();

    sub_norm_26b #(.SHIFT_STEP(STEP), .EXP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [25:0] frac;
        logic        sticky;
        logic [7:0]  expo;
        logic        sign;
        logic        zero;
        logic        denorm;
        logic        inf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Position of the leading one decides everything: right shift, left shift or flag
    function automatic exp_t model(input logic ovf, input logic [26:0] sum,
                                   input logic [7:0] ein, input logic sgn);
        exp_t        r;
        logic [27:0] v;
        int          p, e, k, need;
        v = {ovf, sum};
        p = -1;
        e = int'(ein);
        r.frac = '0; r.sticky = 1'b0; r.expo = '0; r.sign = sgn;
        r.zero = 1'b0; r.denorm = 1'b0; r.inf = 1'b0; r.lat = 1; r.acc = 0;
        for (int i = 0; i < 28; i++) if (v[i]) p = i;
        if (p < 0) begin
            r.zero = 1'b1;
        end else if (p >= 25) begin
            e = e + (p - 25);
            if (e >= 255) begin
                r.inf = 1'b1;
                r.expo = 8'hFF;
            end else begin
                r.frac   = 26'(v >> (p - 25));
                r.sticky = (p > 25) && ((v & ((28'd1 << (p - 25)) - 28'd1)) != 0);
                r.expo   = 8'(e);
            end
        end else begin
            need = 25 - p;
            k    = (e - 1 < 0) ? 0 : e - 1;
            if (k > need) k = need;
`ifndef SUB_NORM_LZC_EN
            r.lat = (k + STEP - 1) / STEP;
            if (r.lat < 1) r.lat = 1;
`endif
            r.frac = 26'(v << k);
            if (k < need) r.denorm = 1'b1;
            else          r.expo   = 8'(e - k);
        end
        return r;
    endfunction

    // Compare process: every cycle the result is presented it must match the model
    bit seen = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                        seen = 1'b1;
                    end
                    chk("frac_out", bus.frac_out, exp_q[0].frac);
                    chk("sticky",   bus.sticky,   exp_q[0].sticky);
                    chk("exp_out",  bus.exp_out,  exp_q[0].expo);
                    chk("sign_out", bus.sign_out, exp_q[0].sign);
                    chk("zero",     bus.zero,     exp_q[0].zero);
                    chk("denorm",   bus.denorm,   exp_q[0].denorm);
                    chk("inf",      bus.inf,      exp_q[0].inf);
                    chk("in_ready_done", bus.in_ready, 1'b0);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic run_beat(input logic ovf, input logic [26:0] sum, input logic [7:0] ein,
                            input logic sgn, input int hold);
        exp_t m;
        bit   got;
        m = model(ovf, sum, ein, sgn);
        @(posedge clk); #1;
        chk("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1; bus.ovf = ovf; bus.sum = sum; bus.exp_in = ein; bus.sign_in = sgn;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        m.acc = cyc;
        exp_q.push_back(m);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.out_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            repeat (hold) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk("out_valid_drop", bus.out_valid, 1'b0);
            chk("in_ready_back", bus.in_ready, 1'b1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_frac_out"},  bus.frac_out,  26'd0);
        chk({tag, "_sticky"},    bus.sticky,    1'b0);
        chk({tag, "_exp_out"},   bus.exp_out,   8'd0);
        chk({tag, "_sign_out"},  bus.sign_out,  1'b0);
        chk({tag, "_flags"},     {bus.zero, bus.denorm, bus.inf}, 3'b000);
    endtask

    typedef struct {
        logic        ovf;
        logic [26:0] sum;
        logic [7:0]  ein;
        logic        sgn;
        int          hold;
    } vec_t;

    vec_t vecs[$];
    exp_t t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.ovf = 1'b0; bus.sum = '0; bus.exp_in = '0;
        bus.sign_in = 1'b0; bus.out_ready = 1'b0;

        t = model(1'b0, 27'h2000000, 8'd100, 1'b0);
        chk("pin_norm_frac", t.frac, 26'h2000000);
        chk("pin_norm_exp",  t.expo, 8'd100);
        chk("pin_norm_lat",  t.lat,  1);
        t = model(1'b1, 27'h0000003, 8'd100, 1'b0);
        chk("pin_ovf_exp",   t.expo, 8'd102);
        chk("pin_ovf_sticky", t.sticky, 1'b1);
        chk("pin_ovf_frac",  t.frac, 26'h2000000);
        t = model(1'b0, 27'h0000001, 8'd127, 1'b0);
        chk("pin_lshift_exp", t.expo, 8'd102);
`ifndef SUB_NORM_LZC_EN
        chk("pin_lshift_lat", t.lat, 7);
`endif
        t = model(1'b0, 27'h0000100, 8'd3, 1'b0);
        chk("pin_denorm", {t.denorm, t.expo, t.frac}, {1'b1, 8'd0, 26'h0000400});
        t = model(1'b0, 27'h4000000, 8'd254, 1'b0);
        chk("pin_inf", {t.inf, t.expo, t.frac}, {1'b1, 8'hFF, 26'd0});
        t = model(1'b0, 27'h0, 8'd50, 1'b0);
        chk("pin_zero", {t.zero, t.expo}, {1'b1, 8'd0});

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        vecs = '{
            '{1'b0, 27'h2000000, 8'd100, 1'b0, 0},
            '{1'b1, 27'h0000003, 8'd100, 1'b1, 0},
            '{1'b0, 27'h0000001, 8'd127, 1'b0, 2},
            '{1'b0, 27'h0000100, 8'd3,   1'b1, 0},
            '{1'b0, 27'h4000000, 8'd254, 1'b0, 0},
            '{1'b0, 27'h0000000, 8'd50,  1'b1, 0},
            '{1'b0, 27'h4000001, 8'd10,  1'b0, 5},
            '{1'b1, 27'h7FFFFFF, 8'd200, 1'b1, 0},
            '{1'b0, 27'h0123456, 8'd0,   1'b0, 0},
            '{1'b0, 27'h0000F00, 8'd1,   1'b0, 0},
            '{1'b0, 27'h0800000, 8'd2,   1'b1, 0},
            '{1'b0, 27'h0400000, 8'd30,  1'b0, 1},
            '{1'b0, 27'h0000010, 8'd19,  1'b0, 0},
            '{1'b1, 27'h0000000, 8'd253, 1'b1, 0},
            '{1'b0, 27'h1FFFFFF, 8'd5,   1'b0, 0},
            '{1'b0, 27'h0000001, 8'd26,  1'b1, 0}
        };
        foreach (vecs[i]) run_beat(vecs[i].ovf, vecs[i].sum, vecs[i].ein, vecs[i].sgn, vecs[i].hold);

        // Reset in the middle of a long left-shift sequence discards the beat
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.ovf = 1'b0; bus.sum = 27'h0000001; bus.exp_in = 8'd127; bus.sign_in = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("in_ready_norm", bus.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("mid_rst");
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_valid", bus.out_valid, 1'b0);

        run_beat(1'b0, 27'h0C00000, 8'd40, 1'b1, 0);
        run_beat(1'b1, 27'h4000002, 8'd7,  1'b0, 0);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
